dpbram_port_arbiter: RTL and testbench

- Shares the single PL-side DPBRAM port (9-bit address, 16-bit data) between NUM_REQ requesters.
  - Requester 0 is the XINTF transfer sequencer.
  - Requesters 1..NUM_REQ-1 are PS register access, waveform loader, etc.
- Each access is sequenced as a fixed 2-clock RAM cycle (setup + access), matching DPBRAM R/W timing.
- Requester 0 has fixed top priority; the others are served round-robin.
- A lock input lets a requester keep the port for a burst.

---
 rtl/dpbram_port_arbiter_pkg.sv | 27 ++
 rtl/dpbram_port_arbiter_rr_picker.sv | 37 +++
 rtl/dpbram_port_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_dpbram_port_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpbram_port_arbiter_pkg.sv
// Shared types and constants for the DPBRAM port arbiter.
// State encoding, default RAM geometry, requester indices and the round-robin pointer step.
package dpbram_arb_pkg;

  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_ACK    = 2'd3
  } arb_state_e;

  localparam int DPB_ADDR_W = 9;
  localparam int DPB_DATA_W = 16;

  localparam int REQ_XINTF = 0;
  localparam int REQ_PS    = 1;
  localparam int REQ_WF    = 2;

  // Pointer to the low-priority requester after 'owner'; range is 1..num_req-1.
  function automatic logic [2:0] rr_advance(input logic [2:0] owner, input int num_req);
    if (int'(owner) >= num_req - 1) begin
      return 3'd1;
    end
    return owner + 3'd1;
  endfunction

endpackage

// File: rtl/dpbram_port_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after start_i (wrapping).
// Returns the winner as one-hot and as a binary index.
module rr_picker #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] start_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic [N-1:0]     rot;
  logic [IDX_W-1:0] pos;
  logic [IDX_W:0]   sum;

  always_comb begin
    // Rotate so start_i lands at bit 0, then take the lowest set bit.
    rot     = N'({req_i, req_i} >> start_i);
    valid_o = 1'b0;
    pos     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        valid_o = 1'b1;
        pos     = IDX_W'(i);
      end
    end
    sum = {1'b0, start_i} + {1'b0, pos};
    if (sum >= (IDX_W + 1)'(N)) begin
      sum = sum - (IDX_W + 1)'(N);
    end
    idx_o = sum[IDX_W-1:0];
    gnt_o = valid_o ? (N'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/dpbram_port_arbiter.sv
// Shares one DPBRAM port among NUM_REQ requesters with a fixed 4-state RAM cycle.
// Requester 0 has top priority, the rest rotate; a lock keeps the port for bursts.
module dpbram_port_arbiter
  import dpbram_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = DPB_ADDR_W,
  parameter int DATA_W  = DPB_DATA_W
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ-1:0]        i_lock,
  input  logic [NUM_REQ-1:0]        i_we,
  input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_din,
  output logic [NUM_REQ-1:0]        o_gnt,
  output logic [NUM_REQ-1:0]        o_ack,
  output logic [DATA_W-1:0]         o_rdata,
  output logic [ADDR_W-1:0]         o_ram_addr,
  output logic                      o_ram_ce,
  output logic                      o_ram_we,
  output logic [DATA_W-1:0]         o_ram_din,
  input  logic [DATA_W-1:0]         i_ram_dout,
  output logic                      o_busy,
  output logic [2:0]                o_owner
);

  localparam int NUM_LO   = NUM_REQ - 1;
  localparam int LO_IDX_W = (NUM_LO > 1) ? $clog2(NUM_LO) : 1;

  arb_state_e          state_q;
  logic [2:0]          rr_ptr_q;
  logic [2:0]          owner_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [NUM_REQ-1:0]  ack_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [DATA_W-1:0]   ram_din_q;
  logic                ram_ce_q;
  logic                ram_we_q;

  logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
  logic [DATA_W-1:0]   data_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi] = i_addr[gi*ADDR_W +: ADDR_W];
      assign data_arr[gi] = i_din[gi*DATA_W +: DATA_W];
    end
  endgenerate

  logic [NUM_LO-1:0]   lo_gnt;
  logic [LO_IDX_W-1:0] lo_idx;
  logic [LO_IDX_W-1:0] lo_start;
  logic                lo_valid;

  assign lo_start = LO_IDX_W'(rr_ptr_q - 3'd1);

  rr_picker #(
    .N     (NUM_LO),
    .IDX_W (LO_IDX_W)
  ) u_rr_picker (
    .req_i   (i_req[NUM_REQ-1:1]),
    .start_i (lo_start),
    .gnt_o   (lo_gnt),
    .idx_o   (lo_idx),
    .valid_o (lo_valid)
  );

  logic [NUM_REQ-1:0] owner_oh;
  logic               lock_hit;
  logic               win_valid;
  logic [2:0]         win_idx;
  logic [NUM_REQ-1:0] win_oh;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_din;
  logic               sel_we;

  always_comb begin
    owner_oh = NUM_REQ'(1) << owner_q;
    // A low-priority lock never blocks requester 0.
    lock_hit = (|(owner_oh & i_lock & i_req)) &&
               !((owner_q != 3'd0) && i_req[REQ_XINTF]);
    win_valid = 1'b1;
    win_idx   = owner_q;
    win_oh    = owner_oh;
    if (lock_hit) begin
      win_idx = owner_q;
      win_oh  = owner_oh;
    end else if (i_req[REQ_XINTF]) begin
      win_idx = 3'd0;
      win_oh  = NUM_REQ'(1);
    end else if (lo_valid) begin
      win_idx = 3'(lo_idx) + 3'd1;
      win_oh  = {lo_gnt, 1'b0};
    end else begin
      win_valid = 1'b0;
      win_idx   = 3'd0;
      win_oh    = '0;
    end

    sel_addr = '0;
    sel_din  = '0;
    sel_we   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx == 3'(k)) begin
        sel_addr = addr_arr[k];
        sel_din  = data_arr[k];
        sel_we   = i_we[k];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_ARB;
      rr_ptr_q   <= 3'd1;
      owner_q    <= 3'd0;
      gnt_q      <= '0;
      ack_q      <= '0;
      rdata_q    <= '0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ram_ce_q   <= 1'b0;
      ram_we_q   <= 1'b0;
    end else begin
      ack_q <= '0;
      case (state_q)
        ST_ARB: begin
          if (win_valid) begin
            state_q    <= ST_SETUP;
            owner_q    <= win_idx;
            gnt_q      <= win_oh;
            ram_addr_q <= sel_addr;
            ram_din_q  <= sel_din;
            ram_we_q   <= sel_we;
            ram_ce_q   <= 1'b1;
          end else begin
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            ram_we_q   <= 1'b0;
            ram_ce_q   <= 1'b0;
          end
        end
        ST_SETUP: begin
          state_q <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // RAM read data is valid here, one clock after the address was presented.
          state_q  <= ST_ACK;
          ram_ce_q <= 1'b0;
          ram_we_q <= 1'b0;
          ack_q    <= gnt_q;
          if (!ram_we_q) begin
            rdata_q <= i_ram_dout;
          end
        end
        ST_ACK: begin
          state_q <= ST_ARB;
          gnt_q   <= '0;
          if (owner_q != 3'd0) begin
            rr_ptr_q <= rr_advance(owner_q, NUM_REQ);
          end
        end
        default: begin
          state_q <= ST_ARB;
        end
      endcase
    end
  end

  assign o_gnt      = gnt_q;
  assign o_ack      = ack_q;
  assign o_rdata    = rdata_q;
  assign o_ram_addr = ram_addr_q;
  assign o_ram_ce   = ram_ce_q;
  assign o_ram_we   = ram_we_q;
  assign o_ram_din  = ram_din_q;
  assign o_busy     = (state_q != ST_ARB);
  assign o_owner    = owner_q;

endmodule

// File: tb/tb_dpbram_port_arbiter.sv
// Directed bench for dpbram_port_arbiter with a small DPBRAM model on the RAM port.
// Each task drives one scenario and compares against hand-derived cycle numbers and data.
module tb_dpbram_port_arbiter;
  import dpbram_arb_pkg::*;

  localparam int NR = 3;
  localparam int AW = 9;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic [NR-1:0]      req, lock, we;
  logic [NR*AW-1:0]   addr;
  logic [NR*DW-1:0]   din;
  logic [NR-1:0]      gnt, ack;
  logic [DW-1:0]      rdata;
  logic [AW-1:0]      ram_addr;
  logic               ram_ce, ram_we;
  logic [DW-1:0]      ram_din;
  logic [DW-1:0]      ram_dout = '0;
  logic               busy;
  logic [2:0]         owner;

  logic               pl_en;
  logic [AW-1:0]      pl_addr;
  logic [DW-1:0]      pl_data;
  logic [DW-1:0]      mem [0:511];

  int checks = 0;
  int errors = 0;

  dpbram_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_lock(lock), .i_we(we),
    .i_addr(addr), .i_din(din), .o_gnt(gnt), .o_ack(ack), .o_rdata(rdata),
    .o_ram_addr(ram_addr), .o_ram_ce(ram_ce), .o_ram_we(ram_we),
    .o_ram_din(ram_din), .i_ram_dout(ram_dout), .o_busy(busy), .o_owner(owner)
  );

  // DPBRAM model: registered read, write on ce&we; preload port for the bench.
  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (ram_ce) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic r, input logic l, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[k]           = r;
    lock[k]          = l;
    we[k]            = w;
    addr[k*AW +: AW] = a;
    din[k*DW +: DW]  = d;
  endtask

  task automatic do_reset();
    req = '0; lock = '0; we = '0; addr = '0; din = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  function automatic int oh2idx(input logic [NR-1:0] v);
    int r = -1;
    for (int i = 0; i < NR; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic test_reset();
    set_req(1, 1'b1, 1'b0, 1'b1, 9'd77, 16'h1111);
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({gnt, ack, ram_ce, ram_we, busy} !== '0) begin
      errors++; $display("FAIL reset_ctrl: gnt=%b ack=%b ce=%b we=%b busy=%b, expected all 0", gnt, ack, ram_ce, ram_we, busy);
    end
    checks++;
    if ({rdata, ram_addr, ram_din} !== '0) begin
      errors++; $display("FAIL reset_data: rdata=%h addr=%0d din=%h, expected 0", rdata, ram_addr, ram_din);
    end
    checks++;
    if (owner !== 3'd0) begin
      errors++; $display("FAIL reset_owner: got %0d expected 0", owner);
    end
    rst = 1'b0;
    set_req(1, 1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    checks++;
    if (busy !== 1'b0 || ram_ce !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: busy=%b ce=%b expected 0 0", busy, ram_ce);
    end
  endtask

  task automatic test_write_read();
    int lat;
    set_req(1, 1'b1, 1'b0, 1'b1, 9'd130, 16'hA5A5);
    tick();
    checks++;
    if (ram_ce !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 9'd130 || ram_din !== 16'hA5A5) begin
      errors++; $display("FAIL wr_setup: ce=%b we=%b addr=%0d din=%h expected 1 1 130 a5a5", ram_ce, ram_we, ram_addr, ram_din);
    end
    checks++;
    if (gnt !== 3'b010 || owner !== 3'd1 || busy !== 1'b1) begin
      errors++; $display("FAIL wr_gnt: gnt=%b owner=%0d busy=%b expected 010 1 1", gnt, owner, busy);
    end
    tick();
    checks++;
    if (ram_ce !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 9'd130) begin
      errors++; $display("FAIL wr_access: ce=%b we=%b addr=%0d expected 1 1 130", ram_ce, ram_we, ram_addr);
    end
    tick();
    checks++;
    if (ram_ce !== 1'b0 || ram_we !== 1'b0 || ack !== 3'b010) begin
      errors++; $display("FAIL wr_ack: ce=%b we=%b ack=%b expected 0 0 010", ram_ce, ram_we, ack);
    end
    set_req(1, 1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    checks++;
    if (ack !== 3'b000 || busy !== 1'b0 || gnt !== 3'b000) begin
      errors++; $display("FAIL wr_done: ack=%b busy=%b gnt=%b expected 000 0 000", ack, busy, gnt);
    end
    checks++;
    if (mem[130] !== 16'hA5A5) begin
      errors++; $display("FAIL wr_mem: mem[130]=%h expected a5a5", mem[130]);
    end
    $display("write  req1 addr=130 data=a5a5");

    set_req(1, 1'b1, 1'b0, 1'b0, 9'd130, '0);
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (lat == 0 && ack[1]) lat = c;
    end
    checks++;
    if (lat != 3) begin
      errors++; $display("FAIL rd_latency: ack after %0d clocks expected 3", lat);
    end
    checks++;
    if (rdata !== 16'hA5A5) begin
      errors++; $display("FAIL rd_data: rdata=%h expected a5a5", rdata);
    end
    set_req(1, 1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    tick();
    $display("read   req1 addr=130 data=%h latency=%0d", rdata, lat);
  endtask

  task automatic test_priority();
    int na, own;
    int a_cyc[4]; int a_own[4]; logic [DW-1:0] a_dat[4];
    na = 0;
    set_req(0, 1'b1, 1'b0, 1'b0, 9'd5, '0);
    set_req(1, 1'b1, 1'b0, 1'b0, 9'd130, '0);
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (ack != '0) begin
        own = oh2idx(ack);
        if (na < 4) begin a_cyc[na] = c; a_own[na] = own; a_dat[na] = rdata; end
        na++;
        set_req(own, 1'b0, 1'b0, 1'b0, '0, '0);
      end
    end
    checks++;
    if (na != 2) begin
      errors++; $display("FAIL prio_count: %0d acks expected 2", na);
    end else begin
      checks++;
      if (a_own[0] != 0 || a_cyc[0] != 3 || a_dat[0] !== 16'h1234) begin
        errors++; $display("FAIL prio_first: owner=%0d cyc=%0d data=%h expected 0 3 1234", a_own[0], a_cyc[0], a_dat[0]);
      end
      checks++;
      if (a_own[1] != 1 || a_cyc[1] - a_cyc[0] != 4 || a_dat[1] !== 16'hA5A5) begin
        errors++; $display("FAIL prio_second: owner=%0d gap=%0d data=%h expected 1 4 a5a5", a_own[1], a_cyc[1] - a_cyc[0], a_dat[1]);
      end
    end
    $display("prio   acks=%0d", na);
  endtask

  task automatic test_round_robin();
    int na, own;
    int a_cyc[8]; int a_own[8];
    int exp_own[4] = '{1, 2, 1, 2};
    do_reset();
    na = 0;
    set_req(1, 1'b1, 1'b0, 1'b0, 9'd130, '0);
    set_req(2, 1'b1, 1'b0, 1'b0, 9'd5, '0);
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (ack != '0) begin
        own = oh2idx(ack);
        if (na < 8) begin a_cyc[na] = c; a_own[na] = own; end
        na++;
      end
    end
    checks++;
    if (na != 4) begin
      errors++; $display("FAIL rr_count: %0d acks expected 4", na);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (a_own[i] != exp_own[i] || a_cyc[i] != 3 + 4 * i) begin
          errors++; $display("FAIL rr_ack%0d: owner=%0d cyc=%0d expected %0d %0d", i, a_own[i], a_cyc[i], exp_own[i], 3 + 4 * i);
        end
      end
    end
    set_req(1, 1'b0, 1'b0, 1'b0, '0, '0);
    set_req(2, 1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) tick();
    $display("rr     acks=%0d", na);
  endtask

  task automatic test_lock_burst(input bit with_req0);
    int na, k2, own;
    int a_cyc[8]; int a_own[8]; logic [DW-1:0] a_dat[8];
    int exp_own_a[5] = '{2, 2, 2, 2, 1};
    int exp_own_b[5] = '{2, 2, 0, 1, 2};
    logic [DW-1:0] exp_dat_a[5] = '{16'hC006, 16'hC007, 16'hC008, 16'hC009, 16'hA5A5};
    logic [DW-1:0] exp_dat_b[5] = '{16'hC006, 16'hC007, 16'h1234, 16'hA5A5, 16'hC008};
    int eo; logic [DW-1:0] ed;
    if (!with_req0) do_reset();
    na = 0; k2 = 0;
    set_req(2, 1'b1, 1'b1, 1'b0, 9'd6, '0);
    for (int c = 1; c <= 22; c++) begin
      tick();
      if (c == 1) set_req(1, 1'b1, 1'b0, 1'b0, 9'd130, '0);
      if (ack != '0) begin
        own = oh2idx(ack);
        if (na < 8) begin a_cyc[na] = c; a_own[na] = own; a_dat[na] = rdata; end
        na++;
        if (own == 2) begin
          k2++;
          if (k2 < 4) set_req(2, 1'b1, 1'b1, 1'b0, 9'(6 + k2), '0);
          else set_req(2, 1'b0, 1'b0, 1'b0, '0, '0);
          if (with_req0 && k2 == 2) set_req(0, 1'b1, 1'b0, 1'b0, 9'd5, '0);
        end else begin
          set_req(own, 1'b0, 1'b0, 1'b0, '0, '0);
        end
      end
    end
    checks++;
    if (na < 5) begin
      errors++; $display("FAIL lock_count%0d: %0d acks expected at least 5", with_req0, na);
    end else begin
      for (int i = 0; i < 5; i++) begin
        eo = with_req0 ? exp_own_b[i] : exp_own_a[i];
        ed = with_req0 ? exp_dat_b[i] : exp_dat_a[i];
        checks++;
        if (a_own[i] != eo || a_cyc[i] != 3 + 4 * i || a_dat[i] !== ed) begin
          errors++; $display("FAIL lock%0d_ack%0d: owner=%0d cyc=%0d data=%h expected %0d %0d %h",
                             with_req0, i, a_own[i], a_cyc[i], a_dat[i], eo, 3 + 4 * i, ed);
        end
      end
    end
    req = '0; lock = '0;
    for (int i = 0; i < 6; i++) tick();
    $display("lock   preempt=%0d acks=%0d", with_req0, na);
  endtask

  task automatic test_reset_mid_access();
    int lat;
    set_req(1, 1'b1, 1'b0, 1'b1, 9'd200, 16'hBEEF);
    tick();
    checks++;
    if (gnt !== 3'b010) begin
      errors++; $display("FAIL rst_mid_gnt: gnt=%b expected 010", gnt);
    end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({gnt, ack, ram_ce, ram_we, busy, owner} !== '0 || ram_addr !== '0 || ram_din !== '0) begin
      errors++; $display("FAIL rst_mid_out: gnt=%b ack=%b ce=%b we=%b busy=%b owner=%0d addr=%0d, expected all 0",
                         gnt, ack, ram_ce, ram_we, busy, owner, ram_addr);
    end
    checks++;
    if (rdata !== '0) begin
      errors++; $display("FAIL rst_mid_rdata: rdata=%h expected 0", rdata);
    end
    rst = 1'b0;
    set_req(1, 1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    checks++;
    if (ack !== 3'b000 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_noack: ack=%b busy=%b expected 000 0", ack, busy);
    end
    set_req(2, 1'b1, 1'b0, 1'b0, 9'd130, '0);
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (lat == 0 && ack[2]) lat = c;
      if (ack[2]) set_req(2, 1'b0, 1'b0, 1'b0, '0, '0);
    end
    checks++;
    if (lat != 3 || rdata !== 16'hA5A5) begin
      errors++; $display("FAIL rst_mid_next: latency=%0d rdata=%h expected 3 a5a5", lat, rdata);
    end
    $display("rstmid next_latency=%0d", lat);
  endtask

  task automatic test_drop_in_setup();
    int nack;
    set_req(2, 1'b1, 1'b0, 1'b1, 9'd300, 16'h5A5A);
    tick();
    set_req(2, 1'b0, 1'b0, 1'b0, 9'd301, 16'h0F0F);
    tick();
    checks++;
    if (ram_ce !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 9'd300 || ram_din !== 16'h5A5A) begin
      errors++; $display("FAIL drop_access: ce=%b we=%b addr=%0d din=%h expected 1 1 300 5a5a", ram_ce, ram_we, ram_addr, ram_din);
    end
    nack = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (ack[2]) nack++;
    end
    checks++;
    if (nack != 1) begin
      errors++; $display("FAIL drop_ack: %0d acks expected 1", nack);
    end
    checks++;
    if (mem[300] !== 16'h5A5A || mem[301] !== 16'h0000) begin
      errors++; $display("FAIL drop_mem: mem[300]=%h mem[301]=%h expected 5a5a 0000", mem[300], mem[301]);
    end
    checks++;
    if (busy !== 1'b0 || rdata !== 16'hA5A5) begin
      errors++; $display("FAIL drop_idle: busy=%b rdata=%h expected 0 a5a5", busy, rdata);
    end
    $display("drop   req2 write addr=300 acks=%0d", nack);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req = '0; lock = '0; we = '0; addr = '0; din = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    tick();
    preload(9'd5, 16'h1234);
    preload(9'd6, 16'hC006);
    preload(9'd7, 16'hC007);
    preload(9'd8, 16'hC008);
    preload(9'd9, 16'hC009);
    preload(9'd301, 16'h0000);
    test_reset();
    test_write_read();
    test_priority();
    test_round_robin();
    test_lock_burst(1'b0);
    test_lock_burst(1'b1);
    test_reset_mid_access();
    test_drop_in_setup();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
